req_ack_fifo_source: RTL and testbench
======================================

# req_ack_fifo_source

Buffered responder for the req/ack pull handshake used between producers, `async_operator` stages and consumers. A local push interface loads words into a circular FIFO, and a downstream initiator drains them. The initiator is typically an `in` operator's `req_l` or a bench consumer. The block replaces the free-running test producer wherever stimulus must be a fixed, pre-loaded sequence.

## Interface
- `data_width`, 32, word width.
- `addr_width`, 4, pointer width; FIFO depth = 2**`addr_width`.
- `producer_id`, 0, identifier for bench messages only; no functional effect.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `wr_en`  in  1  push strobe.
- `wr_data`  in  `data_width`  push data.
- `full`  out  1  FIFO holds 2**`addr_width` words.
- `empty`  out  1  FIFO holds 0 words.
- `level`  out  `addr_width`+1  current occupancy.
- `overflow`  out  1  sticky; set when a push is dropped.
- `req`  in  1  request from the downstream initiator.
- `ack`  out  1  one-cycle acknowledge; `dout` is valid while high.
- `dout`  out  `data_width`  popped word, held until the next pop.
- `count`  out  32  number of words delivered, wrapping modulo 2**32.

## Operation
- Storage: 2**`addr_width` x `data_width` array, `wr_ptr` and `rd_ptr` (`addr_width` bits each), and an occupancy counter `level`.
- Pointers wrap modulo depth. `full` = (`level` == depth). `empty` = (`level` == 0). Both flags derive from the registered `level`, so they reflect state at the start of the cycle.
- Push accepted: `wr_en` & ~`full`.
  - Effect: `mem[wr_ptr]` <= `wr_data` and `wr_ptr`++.
- Push dropped: `wr_en` & `full`.
  - `overflow` <= 1 and stays set until reset.
  - Memory, `wr_ptr` and `level` are unchanged.
- Pop condition: `req` & ~`ack` & ~`empty`.
  - `ack` <= 1, `dout` <= `mem[rd_ptr]`, `rd_ptr`++, `count`++.
- `ack` defaults to 0 every cycle, so it is never high for two consecutive cycles.
- `dout` is unchanged on cycles without a pop.
- Simultaneous accepted push and pop: `level` unchanged and both pointers advance.
  - If `level` was depth, the push is dropped (`full` is the registered value) and `level` becomes depth-1.
  - If `level` was 0, no pop occurs (`empty` is registered); the written word is popped at the earliest next cycle.
- `req` low or `empty`: no `ack`, and no state change on the read side.
- `level` update: +1 on push only, -1 on pop only, unchanged on both or neither.

## Timing
- Reset (`rst`=0 at an edge), taking effect at that edge:
  - `ack`=0, `dout`=0, `count`=0, `level`=0, `empty`=1, `full`=0, `overflow`=0, both pointers 0.
  - Memory contents are not cleared.
- Reset mid-operation discards all buffered words. The first edge with `rst`=1 operates normally from the reset state.
- Push-to-ack latency: a push accepted at edge N deasserts `empty` after N. With `req` high, `ack` rises at edge N+1.
- Maximum drain rate is one word per 2 cycles: `ack` at edges N+1, N+3, N+5, ... while `req` stays high.
- Pop is decided on the registered `ack`. An initiator that holds `req` high across the ack cycle gets exactly one word per ack pulse.
- `full` asserts the cycle after the push that makes `level` = depth. `overflow` asserts the cycle after the dropped push.

## Test plan
- Reset check: hold `rst`=0 for 2 cycles with `wr_en`=1 and `req`=1.
  - Required: `ack`=0, `dout`=0, `count`=0, `level`=0, `empty`=1, `full`=0, `overflow`=0 throughout.
- Basic drain: push 10, 11, 12 on consecutive cycles, then hold `req`=1.
  - Required: `ack` pulses on alternate cycles with `dout` = 10, 11, 12.
  - Required: `count`=3, `empty`=1, no fourth `ack`.
- Full/overflow: push 0..16 (17 pushes, depth 16) with `req`=0.
  - Required: `full`=1, `level`=16, `overflow`=1 after the 17th push.
  - Then drain. Required: `dout` 0..15 in order, word 16 never appears, `overflow` remains 1.
- Simultaneous events:
  - At `level`=16: push plus pop in one cycle gives `level`=15 with the pushed word dropped.
  - At `level`=5: push plus pop gives `level`=5 and FIFO order preserved.
- Wrap-around: stream 40 words (values 100..139) through the depth-16 FIFO with interleaved pushes and pops.
  - Required: output exactly 100..139 in order, `count`=40, `overflow`=0.
- Reset mid-drain: load 8 words, pop 3, assert `rst` for 1 cycle.
  - Required: `level`=0, `count`=0, no `ack` with `req` high.
  - Then push 55 and pop. Required: `dout`=55.

Source files
------------

// File: rtl/req_ack_fifo_source_if.sv
`default_nettype none
// ============================================================================
// Module   : req_ack_fifo_source_if
// Purpose  : Push-side and req/ack pull-side signal bundle for req_ack_fifo_source.
// Revision : 1.0 - initial release
// ============================================================================
interface req_ack_fifo_source_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  i_wr_en;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_full;
  logic                  o_empty;
  logic [ADDR_WIDTH:0]   o_level;
  logic                  o_overflow;
  logic                  i_req;
  logic                  o_ack;
  logic [DATA_WIDTH-1:0] o_dout;
  logic [31:0]           o_count;

  modport slave (
    input  i_wr_en, i_wr_data, i_req,
    output o_full, o_empty, o_level, o_overflow, o_ack, o_dout, o_count
  );

  modport master (
    output i_wr_en, i_wr_data, i_req,
    input  o_full, o_empty, o_level, o_overflow, o_ack, o_dout, o_count
  );
endinterface
`default_nettype wire

// File: rtl/req_ack_fifo_source.sv
`default_nettype none
// ============================================================================
// Module   : req_ack_fifo_source
// Purpose  : Pre-loadable circular FIFO drained by a req/ack pull initiator.
// Revision : 1.0 - initial release
// ============================================================================
module req_ack_fifo_source #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int PRODUCER_ID = 0
) (
  input  wire logic            clk,
  input  wire logic            rst,
  req_ack_fifo_source_if.slave bus
);
  localparam int unsigned         c_DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_LEVEL_FULL = (ADDR_WIDTH + 1)'(c_DEPTH);

  if (PRODUCER_ID < 0) begin : g_id_check
    $error("PRODUCER_ID must be non-negative");
  end

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_overflow;
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [31:0]           r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_drop;
  logic w_pop;

  // Flags come from the registered level, so a push and a pop in the same
  // cycle both see the occupancy at the start of that cycle.
  assign w_full  = (r_level == c_LEVEL_FULL);
  assign w_empty = (r_level == '0);
  assign w_push  = bus.i_wr_en & ~w_full;
  assign w_drop  = bus.i_wr_en & w_full;
  assign w_pop   = bus.i_req & ~r_ack & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wr_ptr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_ack      <= 1'b0;
      r_dout     <= '0;
      r_count    <= '0;
    end else begin
      r_ack <= 1'b0;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_ack    <= 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
        r_count  <= r_count + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (ADDR_WIDTH + 1)'(1);
        2'b01:   r_level <= r_level - (ADDR_WIDTH + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.o_full     = w_full;
  assign bus.o_empty    = w_empty;
  assign bus.o_level    = r_level;
  assign bus.o_overflow = r_overflow;
  assign bus.o_ack      = r_ack;
  assign bus.o_dout     = r_dout;
  assign bus.o_count    = r_count;
endmodule
`default_nettype wire

// File: tb/tb_req_ack_fifo_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_ack_fifo_source
// Purpose  : Directed scoreboard bench for req_ack_fifo_source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_ack_fifo_source;
  localparam int c_DW = 32;
  localparam int c_AW = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [c_DW-1:0] exp_q[$];
  logic prev_ack;

  req_ack_fifo_source_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) bus_if ();

  req_ack_fifo_source #(
    .DATA_WIDTH (c_DW),
    .ADDR_WIDTH (c_AW),
    .PRODUCER_ID(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [c_DW-1:0] d, input bit accepted);
    bus_if.i_wr_en   = 1'b1;
    bus_if.i_wr_data = d;
    if (accepted) exp_q.push_back(d);
    tick();
    bus_if.i_wr_en = 1'b0;
  endtask

  task automatic wait_count(input string name, input logic [31:0] target, input int budget);
    int k;
    k = 0;
    while (bus_if.o_count !== target && k < budget) begin
      tick();
      k++;
    end
    check(name, bus_if.o_count, target);
  endtask

  // Monitor: every ack must carry the next scoreboard word and never repeat back-to-back
  initial begin
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.o_ack === 1'b1) begin
        n_checks++;
        if (prev_ack) begin
          n_fail++;
          $display("FAIL ack_spacing: ack high on two consecutive cycles, required gap");
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: dout=%0d, required no ack", bus_if.o_dout);
        end else begin
          logic [c_DW-1:0] e;
          e = exp_q.pop_front();
          if (bus_if.o_dout !== e) begin
            n_fail++;
            $display("FAIL dout_order: got %0d, required %0d", bus_if.o_dout, e);
          end
        end
      end
      prev_ack = (bus_if.o_ack === 1'b1);
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst              = 1'b0;
    bus_if.i_wr_en   = 1'b1;
    bus_if.i_wr_data = 32'd99;
    bus_if.i_req     = 1'b1;

    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ack",      bus_if.o_ack,      0);
      check("rst_dout",     bus_if.o_dout,     0);
      check("rst_count",    bus_if.o_count,    0);
      check("rst_level",    bus_if.o_level,    0);
      check("rst_empty",    bus_if.o_empty,    1);
      check("rst_full",     bus_if.o_full,     0);
      check("rst_overflow", bus_if.o_overflow, 0);
    end
    rst            = 1'b1;
    bus_if.i_wr_en = 1'b0;
    bus_if.i_req   = 1'b0;
    tick();

    // Basic drain
    push(32'd10, 1'b1);
    push(32'd11, 1'b1);
    push(32'd12, 1'b1);
    check("basic_level", bus_if.o_level, 3);
    bus_if.i_req = 1'b1;
    wait_count("basic_count", 32'd3, 20);
    repeat (4) tick();
    check("basic_count_hold", bus_if.o_count, 3);
    check("basic_empty", bus_if.o_empty, 1);
    bus_if.i_req = 1'b0;

    // Fill to depth, then one dropped push
    for (int i = 0; i < 16; i++) push(32'(i), 1'b1);
    check("fill_full",     bus_if.o_full,     1);
    check("fill_level",    bus_if.o_level,    16);
    check("fill_no_ovf",   bus_if.o_overflow, 0);
    push(32'd16, 1'b0);
    check("ovf_set",       bus_if.o_overflow, 1);
    check("ovf_level",     bus_if.o_level,    16);
    check("ovf_full",      bus_if.o_full,     1);

    // Push and pop together while full: push dropped, level drops by one
    bus_if.i_wr_en   = 1'b1;
    bus_if.i_wr_data = 32'd77;
    bus_if.i_req     = 1'b1;
    tick();
    bus_if.i_wr_en = 1'b0;
    bus_if.i_req   = 1'b0;
    check("simul_full_level", bus_if.o_level, 15);
    check("simul_full_flag",  bus_if.o_full,  0);
    bus_if.i_req = 1'b1;
    wait_count("drain_full_count", 32'd19, 80);
    repeat (3) tick();
    check("drain_ovf_sticky", bus_if.o_overflow, 1);
    check("drain_empty",      bus_if.o_empty,    1);
    bus_if.i_req = 1'b0;

    // Push and pop together at level 5
    for (int i = 0; i < 5; i++) push(32'(200 + i), 1'b1);
    check("mid_level", bus_if.o_level, 5);
    bus_if.i_req = 1'b1;
    push(32'd205, 1'b1);
    bus_if.i_req = 1'b0;
    check("simul_mid_level", bus_if.o_level, 5);
    bus_if.i_req = 1'b1;
    wait_count("mid_drain_count", 32'd25, 40);
    tick();
    bus_if.i_req = 1'b0;

    // Clean reset, then wrap-around stream
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst2_count",    bus_if.o_count,    0);
    check("rst2_overflow", bus_if.o_overflow, 0);
    for (int i = 0; i < 10; i++) push(32'(100 + i), 1'b1);
    bus_if.i_req = 1'b1;
    for (int i = 10; i < 40; i++) begin
      push(32'(100 + i), 1'b1);
      tick();
    end
    wait_count("wrap_count", 32'd40, 100);
    repeat (3) tick();
    check("wrap_overflow", bus_if.o_overflow, 0);
    check("wrap_empty",    bus_if.o_empty,    1);
    bus_if.i_req = 1'b0;

    // Reset in the middle of a drain
    for (int i = 0; i < 8; i++) push(32'(300 + i), 1'b1);
    bus_if.i_req = 1'b1;
    wait_count("middrain_pop3", 32'd43, 20);
    bus_if.i_req = 1'b0;
    tick();
    rst          = 1'b0;
    bus_if.i_req = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b1;
    check("mdrst_level", bus_if.o_level, 0);
    check("mdrst_count", bus_if.o_count, 0);
    check("mdrst_ack",   bus_if.o_ack,   0);
    check("mdrst_empty", bus_if.o_empty, 1);
    tick();
    check("mdrst_no_ack", bus_if.o_ack, 0);
    push(32'd55, 1'b1);
    tick();
    check("latency_ack", bus_if.o_ack,  1);
    check("latency_dout", bus_if.o_dout, 55);
    repeat (3) tick();
    check("final_count", bus_if.o_count, 1);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    bus_if.i_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
